// File: rtl/path_sequencer.sv
// path_sequencer: snapshots a planned path and streams its nodes out over valid/ready.
// Optional handshake watchdog enabled by defining PATH_SEQ_TIMEOUT_EN.
module path_sequencer #(
  parameter int          NODE_W         = 8,
  parameter int          MAX_NODES      = 13,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic              adc_sck,
  input  logic              reset_n,
  input  logic              cpu_done,
  input  logic [NODE_W-1:0] index,
  input  logic [NODE_W-1:0] path0,
  input  logic [NODE_W-1:0] path1,
  input  logic [NODE_W-1:0] path2,
  input  logic [NODE_W-1:0] path3,
  input  logic [NODE_W-1:0] path4,
  input  logic [NODE_W-1:0] path5,
  input  logic [NODE_W-1:0] path6,
  input  logic [NODE_W-1:0] path7,
  input  logic [NODE_W-1:0] path8,
  input  logic [NODE_W-1:0] path9,
  input  logic [NODE_W-1:0] path10,
  input  logic [NODE_W-1:0] path11,
  input  logic [NODE_W-1:0] path12,
  output logic [NODE_W-1:0] node_out,
  output logic              node_valid,
  input  logic              node_ready,
  output logic              path_clear,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [3:0]        node_ptr
);

  localparam int SLOTS = 13;
  localparam logic [NODE_W-1:0] MAX_IDX = NODE_W'(MAX_NODES);
  localparam logic [3:0]        LEN_MAX = 4'(MAX_NODES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  logic [NODE_W-1:0] path_in [SLOTS];
  logic [NODE_W-1:0] arr     [SLOTS];
  logic [3:0]        ptr;
  logic [3:0]        len;
  logic [3:0]        ptr_nxt;
  logic [3:0]        len_in;
  logic              over;

  assign path_in[0]  = path0;
  assign path_in[1]  = path1;
  assign path_in[2]  = path2;
  assign path_in[3]  = path3;
  assign path_in[4]  = path4;
  assign path_in[5]  = path5;
  assign path_in[6]  = path6;
  assign path_in[7]  = path7;
  assign path_in[8]  = path8;
  assign path_in[9]  = path9;
  assign path_in[10] = path10;
  assign path_in[11] = path11;
  assign path_in[12] = path12;

  assign ptr_nxt  = ptr + 4'd1;
  assign over     = index > MAX_IDX;
  assign len_in   = over ? LEN_MAX : index[3:0];
  assign node_ptr = ptr;

`ifdef PATH_SEQ_TIMEOUT_EN
  logic [23:0] wd;
  logic [23:0] wd_nxt;
  assign wd_nxt = wd + 24'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Sequencer FSM: snapshot, issue nodes, hold clear until data memory drops done.
  always_ff @(posedge adc_sck or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      for (int i = 0; i < SLOTS; i++) arr[i] <= '0;
      ptr        <= '0;
      len        <= '0;
      node_out   <= '0;
      node_valid <= 1'b0;
      path_clear <= 1'b0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      seq_err    <= 1'b0;
`ifdef PATH_SEQ_TIMEOUT_EN
      wd         <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          seq_done <= 1'b0;
          if (cpu_done) state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < SLOTS; i++) arr[i] <= path_in[i];
          len      <= len_in;
          seq_err  <= over;
          ptr      <= '0;
          seq_busy <= 1'b1;
`ifdef PATH_SEQ_TIMEOUT_EN
          wd       <= '0;
`endif
          if (len_in == 4'd0) begin
            state      <= CLEAR;
            path_clear <= 1'b1;
          end else begin
            state      <= ISSUE;
            node_valid <= 1'b1;
            node_out   <= path_in[0];
          end
        end
        ISSUE: begin
          if (node_ready) begin
`ifdef PATH_SEQ_TIMEOUT_EN
            wd <= '0;
`endif
            if (ptr == len - 4'd1) begin
              state      <= CLEAR;
              node_valid <= 1'b0;
              path_clear <= 1'b1;
            end else begin
              ptr      <= ptr_nxt;
              node_out <= arr[ptr_nxt];
            end
          end
`ifdef PATH_SEQ_TIMEOUT_EN
          else if (wd_nxt == TIMEOUT_CYCLES) begin
            wd         <= '0;
            state      <= CLEAR;
            node_valid <= 1'b0;
            path_clear <= 1'b1;
            seq_err    <= 1'b1;
          end else begin
            wd <= wd_nxt;
          end
`endif
        end
        CLEAR: begin
          if (!cpu_done) begin
            state      <= DONE;
            path_clear <= 1'b0;
            seq_done   <= 1'b1;
            seq_busy   <= 1'b0;
          end
        end
        DONE: begin
          seq_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_sequencer.sv
// tb_path_sequencer: vector table, random runs and corner sequences
// checked against a queue-based model of the expected node stream.
module tb_path_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cpu_done;
  logic [7:0] index;
  logic [7:0] path [13];
  logic [7:0] node_out;
  logic       node_valid;
  logic       node_ready;
  logic       path_clear;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_err;
  logic [3:0] node_ptr;

  int checks = 0;
  int failures = 0;

  path_sequencer #(
    .NODE_W(8),
    .MAX_NODES(13),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .adc_sck(clk),
    .reset_n(rst_n),
    .cpu_done(cpu_done),
    .index(index),
    .path0(path[0]),
    .path1(path[1]),
    .path2(path[2]),
    .path3(path[3]),
    .path4(path[4]),
    .path5(path[5]),
    .path6(path[6]),
    .path7(path[7]),
    .path8(path[8]),
    .path9(path[9]),
    .path10(path[10]),
    .path11(path[11]),
    .path12(path[12]),
    .node_out(node_out),
    .node_valid(node_valid),
    .node_ready(node_ready),
    .path_clear(path_clear),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .seq_err(seq_err),
    .node_ptr(node_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int mode;
    int drop;
    int exp_n;
    bit exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_path();
    for (int i = 0; i < 13; i++) path[i] = 8'($urandom);
  endtask

  // mode: 0 random ready, 1 ready held, 2 pattern 0,0,1,0,1,1
  task automatic run_path(input int idx, input int mode, input int drop,
                          input int exp_n, input bit exp_err);
    logic [7:0] q[$];
    logic [5:0] pat;
    logic [7:0] pout;
    logic       pv;
    logic       pr;
    int         got;
    int         clr;
    int         cyc;
    bit         done_seen;
    pat = 6'b110100;
    for (int i = 0; i < exp_n; i++) q.push_back(path[i]);
    got = 0;
    clr = 0;
    cyc = 0;
    done_seen = 0;
    pv = 0;
    pr = 0;
    pout = '0;
    index = 8'(idx);
    node_ready = 1'b0;
    cpu_done = 1'b1;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      tick();
      if (pv && !pr) begin
        check("hold_valid", {31'd0, node_valid}, 32'd1);
        check("hold_node", {24'd0, node_out}, {24'd0, pout});
      end
      case (mode)
        1: node_ready = 1'b1;
        2: node_ready = pat[cyc % 6];
        default: node_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      if (node_valid && node_ready) begin
        if (q.size() == 0) begin
          check("extra_node", 32'd1, 32'd0);
        end else begin
          check("node", {24'd0, node_out}, {24'd0, q.pop_front()});
          got++;
        end
      end
      if (path_clear) begin
        check("clear_no_valid", {31'd0, node_valid}, 32'd0);
        check("clear_busy", {31'd0, seq_busy}, 32'd1);
        clr++;
        if (clr == drop) cpu_done = 1'b0;
      end
      if (seq_done) done_seen = 1;
      pv = node_valid;
      pr = node_ready;
      pout = node_out;
    end
    node_ready = 1'b0;
    check("done_seen", {31'd0, done_seen}, 32'd1);
    check("node_count", 32'(got), 32'(exp_n));
    check("seq_err", {31'd0, seq_err}, {31'd0, exp_err});
    check("busy_at_done", {31'd0, seq_busy}, 32'd0);
    check("clear_cycles", 32'(clr), 32'(drop));
    tick();
    check("done_pulse_end", {31'd0, seq_done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_done = 1'b0;
    node_ready = 1'b0;
    index = '0;
    for (int i = 0; i < 13; i++) path[i] = '0;
    #12;
    check("rst_valid", {31'd0, node_valid}, 32'd0);
    check("rst_clear", {31'd0, path_clear}, 32'd0);
    check("rst_busy", {31'd0, seq_busy}, 32'd0);
    check("rst_done", {31'd0, seq_done}, 32'd0);
    check("rst_err", {31'd0, seq_err}, 32'd0);
    check("rst_out", {24'd0, node_out}, 32'd0);
    check("rst_ptr", {28'd0, node_ptr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // exact-timing back-to-back path
    path[0] = 8'h05;
    path[1] = 8'h0A;
    path[2] = 8'h11;
    path[3] = 8'h1E;
    index = 8'd4;
    node_ready = 1'b1;
    cpu_done = 1'b1;
    tick();
    check("lat_load_valid", {31'd0, node_valid}, 32'd0);
    tick();
    check("b2b_v0", {31'd0, node_valid}, 32'd1);
    check("b2b_n0", {24'd0, node_out}, 32'h05);
    check("b2b_busy", {31'd0, seq_busy}, 32'd1);
    tick();
    check("b2b_n1", {24'd0, node_out}, 32'h0A);
    check("b2b_p1", {28'd0, node_ptr}, 32'd1);
    tick();
    check("b2b_n2", {24'd0, node_out}, 32'h11);
    tick();
    check("b2b_n3", {24'd0, node_out}, 32'h1E);
    check("b2b_v3", {31'd0, node_valid}, 32'd1);
    tick();
    check("b2b_vdrop", {31'd0, node_valid}, 32'd0);
    check("b2b_clear", {31'd0, path_clear}, 32'd1);
    tick();
    tick();
    cpu_done = 1'b0;
    check("b2b_clear_hold", {31'd0, path_clear}, 32'd1);
    tick();
    check("b2b_done", {31'd0, seq_done}, 32'd1);
    check("b2b_idle", {31'd0, seq_busy}, 32'd0);
    check("b2b_err", {31'd0, seq_err}, 32'd0);
    check("b2b_clear_off", {31'd0, path_clear}, 32'd0);
    tick();
    check("b2b_done_off", {31'd0, seq_done}, 32'd0);
    node_ready = 1'b0;

    // zero length timing
    index = 8'd0;
    cpu_done = 1'b1;
    tick();
    tick();
    check("zero_clear", {31'd0, path_clear}, 32'd1);
    check("zero_valid", {31'd0, node_valid}, 32'd0);
    cpu_done = 1'b0;
    tick();
    check("zero_done", {31'd0, seq_done}, 32'd1);
    tick();

    // vector table
    vecs.push_back('{4, 1, 3, 4, 1'b0});
    vecs.push_back('{3, 2, 1, 3, 1'b0});
    vecs.push_back('{0, 1, 2, 0, 1'b0});
    vecs.push_back('{20, 1, 1, 13, 1'b1});
    vecs.push_back('{1, 2, 1, 1, 1'b0});
    vecs.push_back('{13, 0, 2, 13, 1'b0});
    vecs.push_back('{14, 2, 1, 13, 1'b1});
    vecs.push_back('{12, 0, 1, 12, 1'b0});
    vecs.push_back('{255, 1, 4, 13, 1'b1});
    foreach (vecs[k]) begin
      rand_path();
      run_path(vecs[k].idx, vecs[k].mode, vecs[k].drop,
               vecs[k].exp_n, vecs[k].exp_err);
    end

    // randomized runs against the length/error model
    for (int r = 0; r < 12; r++) begin
      int ri;
      ri = $urandom_range(0, 20);
      rand_path();
      run_path(ri, $urandom_range(0, 2), $urandom_range(1, 4),
               (ri > 13) ? 13 : ri, ri > 13);
    end

    // reset mid-stream, path still held by data memory
    rand_path();
    index = 8'd5;
    node_ready = 1'b1;
    cpu_done = 1'b1;
    tick();
    tick();
    check("rms_n0", {24'd0, node_out}, {24'd0, path[0]});
    tick();
    tick();
    check("rms_n2", {24'd0, node_out}, {24'd0, path[2]});
    rst_n = 1'b0;
    #1;
    check("rms_valid", {31'd0, node_valid}, 32'd0);
    check("rms_busy", {31'd0, seq_busy}, 32'd0);
    check("rms_out", {24'd0, node_out}, 32'd0);
    check("rms_ptr", {28'd0, node_ptr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rms_reload", {31'd0, node_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rms_restart", {24'd0, node_out}, {24'd0, path[i]});
      check("rms_rvalid", {31'd0, node_valid}, 32'd1);
    end
    tick();
    check("rms_clear", {31'd0, path_clear}, 32'd1);
    cpu_done = 1'b0;
    node_ready = 1'b0;
    tick();
    check("rms_done", {31'd0, seq_done}, 32'd1);
    tick();

`ifdef PATH_SEQ_TIMEOUT_EN
    // watchdog abort with ready held low
    rand_path();
    index = 8'd3;
    node_ready = 1'b0;
    cpu_done = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_still_valid", {31'd0, node_valid}, 32'd1);
    check("to_no_err", {31'd0, seq_err}, 32'd0);
    tick();
    check("to_err", {31'd0, seq_err}, 32'd1);
    check("to_clear", {31'd0, path_clear}, 32'd1);
    check("to_valid_off", {31'd0, node_valid}, 32'd0);
    cpu_done = 1'b0;
    tick();
    check("to_done", {31'd0, seq_done}, 32'd1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
